// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared op codes, constants and FSM state type for the MEM stage
package mem_access_stage_pkg;
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic        RstEnable    = 1'b0;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
  function automatic logic is_load_op(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction
  function automatic logic is_store_op(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
endpackage

// File: rtl/mem_access_stage_load_ext.sv
// mem_load_ext: selects the big-endian byte/half lane of a read word and extends it
module mem_load_ext
  import mem_access_stage_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word[{~addr, 3'b000} +: 8];
  assign h = addr[1] ? word[15:0] : word[31:16];
  // sign or zero extend the selected lane; words pass whole
  always_comb
    result = (aluop == EXE_LB_OP)  ? {{24{b[7]}}, b} :
             (aluop == EXE_LBU_OP) ? {24'h0, b} :
             (aluop == EXE_LH_OP)  ? {{16{h[15]}}, h} :
             (aluop == EXE_LHU_OP) ? {16'h0, h} : word;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage running loads/stores over a req/ack data bus
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush,
  input  logic        data_ack,
  input  logic [31:0] data_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        misalign_o,
  output logic        stallreq
);
  mem_state_t  state, state_n;
  logic [31:0] rdata_q, load_res, st_data;
  logic [3:0]  be;
  logic [1:0]  a;
  logic        kill_q, ld, st, is_byte, is_half, is_word, misalign, go;
  assign a        = mem_addr_i[1:0];
  assign ld       = is_load_op(aluop_i);
  assign st       = is_store_op(aluop_i);
  assign is_byte  = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
  assign is_half  = aluop_i inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
  assign is_word  = aluop_i inside {EXE_LW_OP, EXE_SW_OP};
  assign misalign = (is_half & a[0]) | (is_word & |a);
  assign go       = (ld | st) & ~misalign & ~flush;
  assign be       = is_byte ? 4'b1000 >> a : is_half ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign st_data  = is_byte ? {4{reg2_i[7:0]}} : is_half ? {2{reg2_i[15:0]}} : reg2_i;

  mem_load_ext u_load_ext (
    .aluop (aluop_i),
    .addr  (a),
    .word  (rdata_q),
    .result(load_res)
  );

  // FSM state, read data captured on ack, and a kill bit that survives until DONE
  always_ff @(posedge clk or negedge resetn)
    if (resetn == RstEnable) begin
      state   <= IDLE;
      rdata_q <= ZeroWord;
      kill_q  <= 1'b0;
    end else begin
      state   <= state_n;
      if (state == ACCESS && data_ack) rdata_q <= data_rdata;
      kill_q  <= (state == ACCESS) & (kill_q | flush);
    end

  // next state, bus drive and MEM/WB fields; reset forces every output low
  always_comb begin
    state_n    = state;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_be    = 4'b0000;
    data_addr  = ZeroWord;
    data_wdata = ZeroWord;
    stallreq   = NoStop;
    wd_o       = wd_i;
    wreg_o     = wreg_i & ~st & ~misalign & ~flush;
    wdata_o    = wdata_i;
    whilo_o    = whilo_i & ~flush;
    hi_o       = hi_i;
    lo_o       = lo_i;
    misalign_o = (state == IDLE) & misalign & ~flush;
    case (state)
      IDLE: begin
        stallreq = go ? Stop : NoStop;
        state_n  = go ? ACCESS : IDLE;
      end
      ACCESS: begin
        data_req   = 1'b1;
        data_wr    = st;
        data_be    = be;
        data_addr  = {mem_addr_i[31:2], 2'b00};
        data_wdata = st ? st_data : ZeroWord;
        stallreq   = Stop;
        state_n    = data_ack ? DONE : ACCESS;
      end
      default: begin
        wdata_o = ld ? load_res : wdata_i;
        wreg_o  = wreg_i & ~st & ~kill_q & ~flush;
        whilo_o = whilo_i & ~kill_q & ~flush;
        state_n = IDLE;
      end
    endcase
    if (resetn == RstEnable) begin
      data_req   = 1'b0;
      data_wr    = 1'b0;
      data_be    = 4'b0000;
      data_addr  = ZeroWord;
      data_wdata = ZeroWord;
      stallreq   = NoStop;
      wd_o       = 5'd0;
      wreg_o     = WriteDisable;
      wdata_o    = ZeroWord;
      whilo_o    = WriteDisable;
      hi_o       = ZeroWord;
      lo_o       = ZeroWord;
      misalign_o = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for the MEM access stage
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;
  logic        clk = 1'b0, resetn;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, hi_i, lo_i, data_rdata;
  logic [4:0]  wd_i;
  logic        wreg_i, whilo_i, flush, data_ack;
  logic        data_req, data_wr, wreg_o, whilo_o, misalign_o, stallreq;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, wdata_o, hi_o, lo_o;
  logic [4:0]  wd_o;
  int checks = 0, failures = 0;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_addr, obs_res;
  logic        obs_wr, obs_wreg, obs_done_stall;
  int          obs_stalls, obs_reqs;

  mem_access_stage dut (
    .clk(clk), .resetn(resetn), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
    .flush(flush), .data_ack(data_ack), .data_rdata(data_rdata), .data_req(data_req),
    .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr), .data_wdata(data_wdata),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .misalign_o(misalign_o), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluop_i = EXE_NOP_OP; mem_addr_i = 0; reg2_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0;
    whilo_i = 0; hi_i = 0; lo_i = 0; flush = 0; data_ack = 0; data_rdata = 0;
  endtask

  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rdata, input int ack_delay, input int flush_at);
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = 5'd7; wreg_i = 1'b1;
    wdata_i = 32'h5A5A5A5A; flush = 1'b0;
    #1;
    obs_stalls = int'(stallreq);
    obs_reqs = 0;
    step();
    obs_be = data_be; obs_wdata = data_wdata; obs_wr = data_wr; obs_addr = data_addr;
    for (int i = 0; i <= ack_delay; i++) begin
      flush = (i == flush_at);
      data_ack = (i == ack_delay);
      data_rdata = rdata;
      #1;
      obs_stalls += int'(stallreq);
      obs_reqs += int'(data_req);
      step();
    end
    data_ack = 1'b0; flush = 1'b0;
    #1;
    obs_res = wdata_o; obs_wreg = wreg_o; obs_done_stall = stallreq;
    idle_inputs();
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h100; wreg_i = 1; whilo_i = 1; wdata_i = 32'h1234; wd_i = 5'd3;
    #1;
    checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stallreq); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", data_req); end
    checks++; if ({wreg_o, whilo_o} !== 2'b00) begin failures++; $display("FAIL reset_we: got %b expected 00", {wreg_o, whilo_o}); end
    checks++; if (wdata_o !== 32'h0) begin failures++; $display("FAIL reset_wdata: got %h expected 0", wdata_o); end
    idle_inputs();
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    aluop_i = 8'b0010_0101; wdata_i = 32'h12345678; wreg_i = 1; wd_i = 5'd5; whilo_i = 1;
    hi_i = 32'hAAAA0001; lo_i = 32'hBBBB0002;
    #1;
    checks++; if (wdata_o !== 32'h12345678) begin failures++; $display("FAIL pass_wdata: got %h expected 12345678", wdata_o); end
    checks++; if ({wd_o, wreg_o, whilo_o} !== {5'd5, 2'b11}) begin failures++; $display("FAIL pass_ctl: got %b expected 0010111", {wd_o, wreg_o, whilo_o}); end
    checks++; if ({hi_o, lo_o} !== {32'hAAAA0001, 32'hBBBB0002}) begin failures++; $display("FAIL pass_hilo: got %h expected aaaa0001bbbb0002", {hi_o, lo_o}); end
    checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL pass_stall: got %b expected 0", stallreq); end
    flush = 1;
    #1;
    checks++; if ({wreg_o, whilo_o} !== 2'b00) begin failures++; $display("FAIL pass_flush: got %b expected 00", {wreg_o, whilo_o}); end
    idle_inputs();
    step();
  endtask

  task automatic test_lw();
    run_mem(EXE_LW_OP, 32'h100, 32'h0, 32'hDEADBEEF, 0, -1);
    checks++; if (obs_stalls !== 2) begin failures++; $display("FAIL lw_stalls: got %0d expected 2", obs_stalls); end
    checks++; if (obs_be !== 4'b1111) begin failures++; $display("FAIL lw_be: got %b expected 1111", obs_be); end
    checks++; if ({obs_addr, obs_wr} !== {32'h100, 1'b0}) begin failures++; $display("FAIL lw_addr: got %h/%b expected 100/0", obs_addr, obs_wr); end
    checks++; if (obs_res !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data: got %h expected deadbeef", obs_res); end
    checks++; if ({obs_wreg, obs_done_stall} !== 2'b10) begin failures++; $display("FAIL lw_done: got %b expected 10", {obs_wreg, obs_done_stall}); end
  endtask

  task automatic test_loads_ext();
    run_mem(EXE_LB_OP, 32'h103, 32'h0, 32'h112233F0, 0, -1);
    checks++; if (obs_res !== 32'hFFFFFFF0) begin failures++; $display("FAIL lb_data: got %h expected fffffff0", obs_res); end
    checks++; if ({obs_be, obs_addr} !== {4'b0001, 32'h100}) begin failures++; $display("FAIL lb_bus: got %b/%h expected 0001/100", obs_be, obs_addr); end
    run_mem(EXE_LBU_OP, 32'h103, 32'h0, 32'h112233F0, 0, -1);
    checks++; if (obs_res !== 32'h000000F0) begin failures++; $display("FAIL lbu_data: got %h expected 000000f0", obs_res); end
    checks++; if (obs_be !== 4'b0001) begin failures++; $display("FAIL lbu_be: got %b expected 0001", obs_be); end
    run_mem(EXE_LH_OP, 32'h202, 32'h0, 32'h12348765, 1, -1);
    checks++; if ({obs_res, obs_be} !== {32'hFFFF8765, 4'b0011}) begin failures++; $display("FAIL lh_data: got %h/%b expected ffff8765/0011", obs_res, obs_be); end
    run_mem(EXE_LHU_OP, 32'h200, 32'h0, 32'h87651234, 0, -1);
    checks++; if ({obs_res, obs_be} !== {32'h00008765, 4'b1100}) begin failures++; $display("FAIL lhu_data: got %h/%b expected 00008765/1100", obs_res, obs_be); end
  endtask

  task automatic test_stores();
    run_mem(EXE_SH_OP, 32'h102, 32'h0000ABCD, 32'h0, 0, -1);
    checks++; if ({obs_wr, obs_be} !== 5'b1_0011) begin failures++; $display("FAIL sh_bus: got %b/%b expected 1/0011", obs_wr, obs_be); end
    checks++; if (obs_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata: got %h expected abcdabcd", obs_wdata); end
    checks++; if ({obs_wreg, obs_res} !== {1'b0, 32'h5A5A5A5A}) begin failures++; $display("FAIL sh_wb: got %b/%h expected 0/5a5a5a5a", obs_wreg, obs_res); end
    run_mem(EXE_SB_OP, 32'h101, 32'h000000A5, 32'h0, 0, -1);
    checks++; if ({obs_wdata, obs_be} !== {32'hA5A5A5A5, 4'b0100}) begin failures++; $display("FAIL sb_bus: got %h/%b expected a5a5a5a5/0100", obs_wdata, obs_be); end
    run_mem(EXE_SW_OP, 32'h104, 32'hCAFEF00D, 32'h0, 2, -1);
    checks++; if ({obs_wdata, obs_be, obs_addr} !== {32'hCAFEF00D, 4'b1111, 32'h104}) begin failures++; $display("FAIL sw_bus: got %h/%b/%h expected cafef00d/1111/104", obs_wdata, obs_be, obs_addr); end
    checks++; if (obs_wreg !== 1'b0) begin failures++; $display("FAIL sw_wreg: got %b expected 0", obs_wreg); end
  endtask

  task automatic test_misalign();
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h101; wreg_i = 1; wdata_i = 32'h77;
    #1;
    checks++; if ({data_req, stallreq} !== 2'b00) begin failures++; $display("FAIL mis_lw_bus: got %b expected 00", {data_req, stallreq}); end
    checks++; if ({misalign_o, wreg_o} !== 2'b10) begin failures++; $display("FAIL mis_lw_flags: got %b expected 10", {misalign_o, wreg_o}); end
    step();
    checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL mis_lw_noreq: got %b expected 0", data_req); end
    aluop_i = EXE_LH_OP; mem_addr_i = 32'h201;
    #1;
    checks++; if ({misalign_o, stallreq} !== 2'b10) begin failures++; $display("FAIL mis_lh: got %b expected 10", {misalign_o, stallreq}); end
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h100; wreg_i = 1; whilo_i = 1; flush = 1;
    #1;
    checks++; if ({stallreq, wreg_o, whilo_o} !== 3'b000) begin failures++; $display("FAIL flush_idle: got %b expected 000", {stallreq, wreg_o, whilo_o}); end
    step();
    checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL flush_idle_req: got %b expected 0", data_req); end
    idle_inputs();
    step();
    run_mem(EXE_LH_OP, 32'h200, 32'h0, 32'h80001234, 5, 1);
    checks++; if (obs_reqs !== 6) begin failures++; $display("FAIL flush_acc_reqs: got %0d expected 6", obs_reqs); end
    checks++; if (obs_stalls !== 7) begin failures++; $display("FAIL flush_acc_stalls: got %0d expected 7", obs_stalls); end
    checks++; if ({obs_wreg, obs_res} !== {1'b0, 32'hFFFF8000}) begin failures++; $display("FAIL flush_acc_done: got %b/%h expected 0/ffff8000", obs_wreg, obs_res); end
    run_mem(EXE_LW_OP, 32'h300, 32'h0, 32'h0BADF00D, 2, 2);
    checks++; if ({obs_wreg, obs_res} !== {1'b0, 32'h0BADF00D}) begin failures++; $display("FAIL flush_with_ack: got %b/%h expected 0/0badf00d", obs_wreg, obs_res); end
  endtask

  task automatic test_ack_outside();
    data_ack = 1; data_rdata = 32'hFFFFFFFF; wdata_i = 32'h42; wreg_i = 1;
    step();
    checks++; if ({stallreq, data_req, wdata_o} !== {2'b00, 32'h42}) begin failures++; $display("FAIL ack_idle: got %b/%h expected 00/42", {stallreq, data_req}, wdata_o); end
    idle_inputs();
    run_mem(EXE_LBU_OP, 32'h100, 32'h0, 32'h9A000000, 0, -1);
    checks++; if (obs_res !== 32'h0000009A) begin failures++; $display("FAIL ack_idle_next: got %h expected 0000009a", obs_res); end
  endtask

  task automatic test_reset_mid_access();
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h100; wreg_i = 1;
    #1;
    step();
    checks++; if (data_req !== 1'b1) begin failures++; $display("FAIL rst_pre_req: got %b expected 1", data_req); end
    #2 resetn = 1'b0;
    #1;
    checks++; if ({data_req, stallreq} !== 2'b00) begin failures++; $display("FAIL rst_async_drop: got %b expected 00", {data_req, stallreq}); end
    #2 resetn = 1'b1;
    #1;
    checks++; if ({data_req, stallreq} !== 2'b01) begin failures++; $display("FAIL rst_resume_idle: got %b expected 01", {data_req, stallreq}); end
    step();
    checks++; if (data_req !== 1'b1) begin failures++; $display("FAIL rst_resume_req: got %b expected 1", data_req); end
    data_ack = 1; data_rdata = 32'h13579BDF;
    step();
    data_ack = 0;
    #1;
    checks++; if ({wdata_o, stallreq} !== {32'h13579BDF, 1'b0}) begin failures++; $display("FAIL rst_resume_data: got %h/%b expected 13579bdf/0", wdata_o, stallreq); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_loads_ext();
    test_stores();
    test_misalign();
    test_flush();
    test_ack_outside();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
